multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath; replaces single-cycle MAIN_CONTROL when IM/DM share a stalling memory.
//  Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the mux selects and write enables per state.
//  Waits on a memory ready handshake, bounds that wait with a timeout, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting on i_MemReady before fault; 0 disables timeout
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst_n        in   1      asynchronous active-low reset
//  i_OPCode       in   7      IR[6:0], valid from DECODE onward
//  i_MemReady     in   1      memory completes current read/write this cycle
//  o_PCWrite      out  1      unconditional PC <= PC+4 (fetch)
//  o_PCWriteCond  out  1      PC <= OldPC + (imm<<1) if ALU_Zero
//  o_IRWrite      out  1      latch fetched word into IR and OldPC
//  o_IorD         out  1      memory address select: 0=PC, 1=ALU_Result
//  o_MemRead      out  1      memory read request
//  o_MemWrite     out  1      memory write request
//  o_MemToReg     out  1      RF write data: 1=memory data, 0=ALU result
//  o_RegWrite     out  1      RF write enable
//  o_ALUSrc       out  1      ALU op2: 1=immediate, 0=rs2
//  o_ALUOp        out  2      00 add, 01 branch compare, 10 funct-decoded
//  o_Retire       out  1      one-cycle pulse per completed instruction
//  o_RetiredCount out  CNT_W  retired instructions, wraps modulo 2^CNT_W
//  o_Halted       out  1      sticky: illegal opcode or memory timeout
//  o_FaultCause   out  2      00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counters 0, o_FaultCause=00, every output 0.
//  - Outputs are Moore decodes of the state, except o_IRWrite/o_PCWrite/o_Retire, which also qualify on i_MemReady.
//  - IDLE: all outputs 0; -> FETCH next cycle.
//  - FETCH: MemRead=1, IorD=0. On i_MemReady: IRWrite=1, PCWrite=1, -> DECODE. Else stay.
//  - DECODE: opcode registered. 0110011 -> EX_R; 0010011 -> EX_I; 0000011/0100011 -> EX_ADDR (load/store flag kept);
//    1100011 -> EX_BR; any other -> HALT, cause 01.
//  - EX_R: ALUSrc=0, ALUOp=10 -> WB_ALU.   EX_I: ALUSrc=1, ALUOp=10 -> WB_ALU.
//  - EX_ADDR: ALUSrc=1, ALUOp=00 -> MEM.
//  - EX_BR: ALUSrc=0, ALUOp=01, PCWriteCond=1, Retire=1 -> FETCH.
//  - MEM: IorD=1; MemRead=1 on load, MemWrite=1 on store. On i_MemReady: load -> WB_MEM;
//    store -> Retire=1, -> FETCH. Else stay; request held stable while waiting.
//  - WB_ALU: RegWrite=1, MemToReg=0, Retire=1 -> FETCH.   WB_MEM: RegWrite=1, MemToReg=1, Retire=1 -> FETCH.
//  - HALT: all outputs 0, o_Halted=1; exit only via reset.
//  - Wait timer: cleared on entry to FETCH/MEM; increments each cycle i_MemReady=0.
//    Reaching MEM_TIMEOUT with no ready -> HALT, cause 10 (FETCH) or 11 (MEM).
//    i_MemReady in the same cycle as the limit wins (no fault).
//  - Latency: R/I/load 5/5/6 cycles with zero wait states (branch 4, store 5), plus one cycle per wait.
//  - o_RetiredCount increments with o_Retire; 2^CNT_W-1 wraps to 0.
//  - Reset asserted mid-MEM: requests drop immediately (async); no write is assumed to complete.
//  - i_MemReady is ignored outside FETCH/MEM.
// STRUCTURE
//  - Shared header rv_control_defs.vh: opcode constants, ALUOp encodings, state encoding, fault-cause codes.
//  - Sub-module mem_wait_timer (clear, tick, limit -> expired) holds the timeout counter.
//  - FSM and output decode stay in this module.
// TESTING
//  1 R-type add, i_MemReady tied 1 -> IDLE,FETCH,DECODE,EX_R,WB_ALU.
//    RegWrite=1 for exactly 1 cycle; o_RetiredCount=1 after 5 cycles.
//  2 Load with ready delayed 3 cycles in FETCH and 2 in MEM -> MemRead held throughout, IorD=1 only in MEM;
//    Retire at cycle 11 with MemToReg=1.
//  3 Store, then branch (0100011, 1100011) -> MemWrite single cycle with ready, no RegWrite;
//    PCWriteCond=1 only in EX_BR; count=2.
//  4 Opcode 0110111 -> HALT, o_FaultCause=01, o_Halted=1, all enables 0 for 20+ cycles;
//    i_rst_n low clears it asynchronously.
//  5 MEM_TIMEOUT=4, ready never in MEM -> HALT cause 11 after 4 wait cycles.
//    Repeat with ready on 4th cycle -> no fault.
//  6 CNT_W=4, 17 back-to-back R-types -> o_RetiredCount wraps 15->0->1.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, ALU op codes, FSM states, fault causes and control bundle for the sequencer
package multicycle_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_ILLEGAL  = 2'b01,
        FAULT_FETCH_TO = 2'b10,
        FAULT_DATA_TO  = 2'b11
    } fault_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EX_R,
        ST_EX_I,
        ST_EX_ADDR,
        ST_EX_BR,
        ST_MEM,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_HALT
    } state_e;

    // Datapath control bundle produced each cycle by the output decode
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       retire;
    } ctrl_t;

    // Execute state selected by an opcode; anything unsupported halts the core
    function automatic state_e decode_target(input logic [6:0] opcode);
        state_e s;
        case (opcode)
            OP_R:              s = ST_EX_R;
            OP_I:              s = ST_EX_I;
            OP_LOAD, OP_STORE: s = ST_EX_ADDR;
            OP_BRANCH:         s = ST_EX_BR;
            default:           s = ST_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - memory handshake and datapath control bundle between sequencer and datapath
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       i_OPCode;
    logic             i_MemReady;
    logic             o_PCWrite;
    logic             o_PCWriteCond;
    logic             o_IRWrite;
    logic             o_IorD;
    logic             o_MemRead;
    logic             o_MemWrite;
    logic             o_MemToReg;
    logic             o_RegWrite;
    logic             o_ALUSrc;
    logic [1:0]       o_ALUOp;
    logic             o_Retire;
    logic [CNT_W-1:0] o_RetiredCount;
    logic             o_Halted;
    logic [1:0]       o_FaultCause;

    modport master (
        input  i_OPCode, i_MemReady,
        output o_PCWrite, o_PCWriteCond, o_IRWrite, o_IorD, o_MemRead, o_MemWrite,
               o_MemToReg, o_RegWrite, o_ALUSrc, o_ALUOp, o_Retire, o_RetiredCount,
               o_Halted, o_FaultCause
    );

    modport slave (
        output i_OPCode, i_MemReady,
        input  o_PCWrite, o_PCWriteCond, o_IRWrite, o_IorD, o_MemRead, o_MemWrite,
               o_MemToReg, o_RegWrite, o_ALUSrc, o_ALUOp, o_Retire, o_RetiredCount,
               o_Halted, o_FaultCause
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// rtl/multicycle_control_mem_wait_timer.sv - counts memory wait cycles and flags the one that reaches the limit
module multicycle_control_mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_count;

    // Count prior wait cycles; clear wins so a fresh request starts from zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + W'(1);
        end
    end

    // Expire on the LIMIT-th consecutive wait cycle; a ready in that cycle suppresses the tick
    generate
        if (LIMIT == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            assign o_expired = i_tick && (r_count == W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I control sequencer with memory wait timeout and retire counter
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    multicycle_control_if.master   bus
);

    state_e           r_state;
    state_e           w_next;
    state_e           w_decoded;
    logic             r_is_store;
    fault_e           r_cause;
    fault_e           w_fault;
    ctrl_t            w_ctrl;
    logic [CNT_W-1:0] r_retired;
    logic             w_in_wait;
    logic             w_timer_clear;
    logic             w_timer_tick;
    logic             w_expired;

    assign w_decoded     = decode_target(bus.i_OPCode);
    assign w_in_wait     = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_timer_tick  = w_in_wait && !bus.i_MemReady;
    assign w_timer_clear = !w_in_wait || bus.i_MemReady;

    multicycle_control_mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_timer_clear),
        .i_tick    (w_timer_tick),
        .o_expired (w_expired)
    );

    // State register, plus the load/store flag captured in DECODE and the sticky fault cause
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_is_store <= 1'b0;
            r_cause    <= FAULT_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_is_store <= (bus.i_OPCode == OP_STORE);
            end
            if (w_fault != FAULT_NONE) begin
                r_cause <= w_fault;
            end
        end
    end

    // Next-state logic; a ready in the limit cycle takes priority over the timeout
    always_comb begin
        w_next  = r_state;
        w_fault = FAULT_NONE;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH: begin
                if (bus.i_MemReady) begin
                    w_next = ST_DECODE;
                end else if (w_expired) begin
                    w_next  = ST_HALT;
                    w_fault = FAULT_FETCH_TO;
                end
            end
            ST_DECODE: begin
                w_next = w_decoded;
                if (w_decoded == ST_HALT) begin
                    w_fault = FAULT_ILLEGAL;
                end
            end
            ST_EX_R, ST_EX_I: w_next = ST_WB_ALU;
            ST_EX_ADDR:       w_next = ST_MEM;
            ST_EX_BR:         w_next = ST_FETCH;
            ST_MEM: begin
                if (bus.i_MemReady) begin
                    w_next = r_is_store ? ST_FETCH : ST_WB_MEM;
                end else if (w_expired) begin
                    w_next  = ST_HALT;
                    w_fault = FAULT_DATA_TO;
                end
            end
            ST_WB_ALU, ST_WB_MEM: w_next = ST_FETCH;
            ST_HALT:              w_next = ST_HALT;
            default:              w_next = ST_IDLE;
        endcase
    end

    // Output decode: Moore per state, with fetch latch and store retire qualified by ready
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ir_write = bus.i_MemReady;
                w_ctrl.pc_write = bus.i_MemReady;
            end
            ST_EX_R: begin
                w_ctrl.alu_op = ALUOP_FUNCT;
            end
            ST_EX_I: begin
                w_ctrl.alu_src = 1'b1;
                w_ctrl.alu_op  = ALUOP_FUNCT;
            end
            ST_EX_ADDR: begin
                w_ctrl.alu_src = 1'b1;
                w_ctrl.alu_op  = ALUOP_ADD;
            end
            ST_EX_BR: begin
                w_ctrl.alu_op        = ALUOP_BR;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.retire        = 1'b1;
            end
            ST_MEM: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_read  = !r_is_store;
                w_ctrl.mem_write = r_is_store;
                w_ctrl.retire    = r_is_store && bus.i_MemReady;
            end
            ST_WB_ALU: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.retire    = 1'b1;
            end
            ST_WB_MEM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.retire     = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retired <= '0;
        end else if (w_ctrl.retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign bus.o_PCWrite      = w_ctrl.pc_write;
    assign bus.o_PCWriteCond  = w_ctrl.pc_write_cond;
    assign bus.o_IRWrite      = w_ctrl.ir_write;
    assign bus.o_IorD         = w_ctrl.iord;
    assign bus.o_MemRead      = w_ctrl.mem_read;
    assign bus.o_MemWrite     = w_ctrl.mem_write;
    assign bus.o_MemToReg     = w_ctrl.mem_to_reg;
    assign bus.o_RegWrite     = w_ctrl.reg_write;
    assign bus.o_ALUSrc       = w_ctrl.alu_src;
    assign bus.o_ALUOp        = w_ctrl.alu_op;
    assign bus.o_Retire       = w_ctrl.retire;
    assign bus.o_RetiredCount = r_retired;
    assign bus.o_Halted       = (r_state == ST_HALT);
    assign bus.o_FaultCause   = r_cause;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int T  = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0110111;

    typedef struct packed {
        logic       pcw;
        logic       pcc;
        logic       irw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       rw;
        logic       src;
        logic [1:0] aluop;
        logic       ret;
        logic       halted;
        logic [1:0] cause;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks  = 0;
    int   n_err     = 0;
    int   model_cnt = 0;
    logic [6:0] ops [5] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};

    multicycle_control_if #(.CNT_W(CW)) bus ();

    multicycle_control #(
        .MEM_TIMEOUT (T),
        .CNT_W       (CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic vec_t obs();
        vec_t o;
        o.pcw    = bus.o_PCWrite;
        o.pcc    = bus.o_PCWriteCond;
        o.irw    = bus.o_IRWrite;
        o.iord   = bus.o_IorD;
        o.mr     = bus.o_MemRead;
        o.mw     = bus.o_MemWrite;
        o.m2r    = bus.o_MemToReg;
        o.rw     = bus.o_RegWrite;
        o.src    = bus.o_ALUSrc;
        o.aluop  = bus.o_ALUOp;
        o.ret    = bus.o_Retire;
        o.halted = bus.o_Halted;
        o.cause  = bus.o_FaultCause;
        return o;
    endfunction

    function automatic vec_t v_zero();
        vec_t e = '0;
        return e;
    endfunction

    function automatic vec_t v_fetch(input logic rdy);
        vec_t e = '0;
        e.mr  = 1'b1;
        e.irw = rdy;
        e.pcw = rdy;
        return e;
    endfunction

    function automatic vec_t v_ex(input logic src, input logic [1:0] aluop, input logic br);
        vec_t e = '0;
        e.src   = src;
        e.aluop = aluop;
        e.pcc   = br;
        e.ret   = br;
        return e;
    endfunction

    function automatic vec_t v_mem(input logic st, input logic rdy);
        vec_t e = '0;
        e.iord = 1'b1;
        e.mr   = !st;
        e.mw   = st;
        e.ret  = st & rdy;
        return e;
    endfunction

    function automatic vec_t v_wb(input logic from_mem);
        vec_t e = '0;
        e.rw  = 1'b1;
        e.m2r = from_mem;
        e.ret = 1'b1;
        return e;
    endfunction

    function automatic vec_t v_halt(input logic [1:0] cause);
        vec_t e = '0;
        e.halted = 1'b1;
        e.cause  = cause;
        return e;
    endfunction

    // One clock: drive after the edge, sample mid-cycle, then account for any retire
    task automatic step(input logic rdy, input logic [6:0] op, input vec_t e, input string tag);
        @(posedge clk);
        #1;
        bus.i_MemReady = rdy;
        bus.i_OPCode   = op;
        @(negedge clk);
        check({tag, "_ctl"}, 64'(obs()), 64'(e));
        check({tag, "_cnt"}, 64'(bus.o_RetiredCount), 64'(model_cnt % (1 << CW)));
        if (e.ret) model_cnt++;
    endtask

    task automatic halt_for(input logic [1:0] cause, input int n);
        for (int k = 0; k < n; k++)
            step(1'($urandom), 7'($urandom), v_halt(cause), "halt");
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.i_MemReady = 1'($urandom);
        #1;
        model_cnt = 0;
        check("reset_ctl", 64'(obs()), 64'(v_zero()));
        check("reset_cnt", 64'(bus.o_RetiredCount), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_ctl", 64'(obs()), 64'(v_zero()));
    endtask

    // Walks one instruction; fw/mw are wait cycles before ready, >= T means ready never comes
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        for (int k = 0; k < fw && k < T; k++)
            step(1'b0, 7'($urandom), v_fetch(1'b0), "fetch_wait");
        if (fw >= T) begin
            halt_for(2'b10, 3);
            return;
        end
        step(1'b1, 7'($urandom), v_fetch(1'b1), "fetch");
        step(1'($urandom), op, v_zero(), "decode");
        case (op)
            OP_R: begin
                step(1'($urandom), op, v_ex(1'b0, 2'b10, 1'b0), "ex_r");
                step(1'($urandom), op, v_wb(1'b0), "wb_alu");
            end
            OP_I: begin
                step(1'($urandom), op, v_ex(1'b1, 2'b10, 1'b0), "ex_i");
                step(1'($urandom), op, v_wb(1'b0), "wb_alu");
            end
            OP_BR: begin
                step(1'($urandom), op, v_ex(1'b0, 2'b01, 1'b1), "ex_br");
            end
            OP_LD, OP_ST: begin
                step(1'($urandom), op, v_ex(1'b1, 2'b00, 1'b0), "ex_addr");
                for (int k = 0; k < mw && k < T; k++)
                    step(1'b0, op, v_mem(op == OP_ST, 1'b0), "mem_wait");
                if (mw >= T) begin
                    halt_for(2'b11, 3);
                    return;
                end
                step(1'b1, op, v_mem(op == OP_ST, 1'b1), "mem");
                if (op == OP_LD)
                    step(1'($urandom), op, v_wb(1'b1), "wb_mem");
            end
            default: halt_for(2'b01, 22);
        endcase
    endtask

    initial begin
        bus.i_MemReady = 1'b0;
        bus.i_OPCode   = 7'd0;
        do_reset();

        run_instr(OP_R, 0, 0);
        run_instr(OP_LD, 3, 2);
        run_instr(OP_ST, 0, 0);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_I, 1, 0);
        run_instr(OP_LD, T - 1, T - 1);
        run_instr(OP_ST, 2, T - 1);

        for (int n = 0; n < 17; n++)
            run_instr(OP_R, 0, 0);

        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, T - 1), $urandom_range(0, T - 1));

        run_instr(OP_BAD, 0, 0);
        do_reset();
        run_instr(7'b1111111, 1, 0);
        do_reset();
        run_instr(OP_ST, 0, T);
        do_reset();
        run_instr(OP_LD, 1, T);
        do_reset();
        run_instr(OP_I, T, 0);
        do_reset();

        // Reset while a store is waiting in MEM: the write request must drop at once
        step(1'b1, 7'($urandom), v_fetch(1'b1), "fetch");
        step(1'b0, OP_ST, v_zero(), "decode");
        step(1'b0, OP_ST, v_ex(1'b1, 2'b00, 1'b0), "ex_addr");
        step(1'b0, OP_ST, v_mem(1'b1, 1'b0), "mem_wait");
        do_reset();
        run_instr(OP_R, 0, 0);
        step(1'b0, 7'($urandom), v_fetch(1'b0), "fetch_wait");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
